match_check: RTL and testbench

MATCH_CHECK -- requirements
Module: match_check

---
 rtl/match_check_pkg.sv | 44 ++++
 rtl/match_check_hold_timer.sv | 47 ++++
 rtl/match_check.sv | 199 +++++++++++++++++++
 tb/tb_match_check.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_check_pkg.sv
// ---------------------------------------------------------------------------
// match_check_pkg
// Shared definitions for the memory-card game: board geometry, the match
// checker state encoding, cursor/select stage definitions and small helpers
// for picking a card value or a board-position mask.
// ---------------------------------------------------------------------------
package match_check_pkg;

  // Board geometry
  localparam int N_CARDS = 16;
  localparam int CARD_W  = 4;
  localparam int IDX_W   = 4;
  localparam int BOARD_W = N_CARDS * CARD_W;

  // Match checker states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FIRST     = 3'd1,
    ST_COMPARE   = 3'd2,
    ST_SHOW_MISS = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // Cursor/select stage definitions (shared with the stage feeding sel_valid)
  localparam int CURSOR_W = IDX_W;
  typedef enum logic [1:0] {
    CUR_NONE   = 2'd0,
    CUR_LEFT   = 2'd1,
    CUR_RIGHT  = 2'd2,
    CUR_SELECT = 2'd3
  } cursor_cmd_e;

  // Value of the card at board position idx
  function automatic logic [CARD_W-1:0] card_at(input logic [BOARD_W-1:0] board,
                                                input logic [IDX_W-1:0]   idx);
    card_at = board[idx*CARD_W +: CARD_W];
  endfunction

  // One-hot mask of board position idx
  function automatic logic [N_CARDS-1:0] idx_mask(input logic [IDX_W-1:0] idx);
    idx_mask = {{(N_CARDS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/match_check_hold_timer.sv
// ---------------------------------------------------------------------------
// hold_timer
// Down-counter that times how long a mismatched pair stays face up.
//   clk, rst     : clock, asynchronous active-high reset
//   load_i       : load load_val_i into the counter (takes priority)
//   load_val_i   : number of cycles to time (1..255)
//   done_o       : registered, high during the last counted cycle
// ---------------------------------------------------------------------------
module hold_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q;

  // Next count: load, else count down to zero and stop
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != {CNT_W{1'b0}}) begin
      count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter and done flag; done is high while the count reads one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= (count_d == {{(CNT_W-1){1'b0}}, 1'b1});
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/match_check.sv
// ---------------------------------------------------------------------------
// match_check
// Turn logic of a two-player memory game: latches two selected cards,
// compares them, scores matches and hides mismatches after a hold time.
//   clk, rst     : clock, asynchronous active-high reset
//   sel_valid    : one-cycle select pulse for the card at sel_idx
//   sel_idx      : board position 0..15
//   cards        : packed board, position k at bits [4k+3:4k]
//   busy         : comparing or holding a mismatch (selections ignored)
//   revealed     : face-up cards (includes matched ones)
//   matched      : cards removed as part of a found pair
//   player       : player to move
//   score0/1     : pairs found per player
//   match_pulse  : one-cycle pulse, pair matched
//   miss_pulse   : one-cycle pulse, pair did not match
//   game_over    : all cards matched, held until reset
// ---------------------------------------------------------------------------
module match_check
  import match_check_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sel_valid,
  input  logic [3:0]   sel_idx,
  input  logic [63:0]  cards,
  output logic         busy,
  output logic [15:0]  revealed,
  output logic [15:0]  matched,
  output logic         player,
  output logic [3:0]   score0,
  output logic [3:0]   score1,
  output logic         match_pulse,
  output logic         miss_pulse,
  output logic         game_over
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx1_q, idx1_d, idx2_q, idx2_d;
  logic [CARD_W-1:0]   val1_q, val1_d, val2_q, val2_d;
  logic [N_CARDS-1:0]  revealed_q, revealed_d, matched_q, matched_d;
  logic                player_q, player_d;
  logic [3:0]          score0_q, score0_d, score1_q, score1_d;
  logic                res_match_q, res_match_d, res_miss_q, res_miss_d;
  logic                match_pulse_q, match_pulse_d, miss_pulse_q, miss_pulse_d;
  logic                busy_q, busy_d;
  logic                game_over_q, game_over_d;
  logic                accept_s;
  logic                timer_load_s;
  logic                timer_done_s;

  hold_timer #(.CNT_W(8)) u_hold_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load_s),
    .load_val_i (8'(HOLD_CYCLES)),
    .done_o     (timer_done_s)
  );

  // Next-state and output logic of the turn FSM
  always_comb begin
    state_d       = state_q;
    idx1_d        = idx1_q;
    idx2_d        = idx2_q;
    val1_d        = val1_q;
    val2_d        = val2_q;
    revealed_d    = revealed_q;
    matched_d     = matched_q;
    player_d      = player_q;
    score0_d      = score0_q;
    score1_d      = score1_q;
    res_match_d   = 1'b0;
    res_miss_d    = 1'b0;
    game_over_d   = game_over_q;
    timer_load_s  = 1'b0;
    // Result is decided at the end of COMPARE and shown one cycle later
    match_pulse_d = res_match_q;
    miss_pulse_d  = res_miss_q;

    // Only IDLE/FIRST take selections; matched cards and re-picking the
    // first card are ignored
    accept_s = sel_valid && !matched_q[sel_idx] &&
               ((state_q == ST_IDLE) ||
                ((state_q == ST_FIRST) && (sel_idx != idx1_q)));

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          idx1_d     = sel_idx;
          val1_d     = card_at(cards, sel_idx);
          revealed_d = revealed_q | idx_mask(sel_idx);
          state_d    = ST_FIRST;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_FIRST: begin
        if (accept_s) begin
          idx2_d     = sel_idx;
          val2_d     = card_at(cards, sel_idx);
          revealed_d = revealed_q | idx_mask(sel_idx);
          state_d    = ST_COMPARE;
        end else begin
          state_d    = ST_FIRST;
        end
      end
      ST_COMPARE: begin
        // Compares the latched values, so the live board no longer matters
        if (val1_q == val2_q) begin
          matched_d   = matched_q | idx_mask(idx1_q) | idx_mask(idx2_q);
          res_match_d = 1'b1;
          if (player_q) begin
            score1_d = score1_q + 4'd1;
          end else begin
            score0_d = score0_q + 4'd1;
          end
          if (&matched_d) begin
            game_over_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d     = ST_IDLE;
          end
        end else begin
          res_miss_d   = 1'b1;
          timer_load_s = 1'b1;
          state_d      = ST_SHOW_MISS;
        end
      end
      ST_SHOW_MISS: begin
        if (timer_done_s) begin
          revealed_d = revealed_q & ~(idx_mask(idx1_q) | idx_mask(idx2_q));
          player_d   = ~player_q;
          state_d    = ST_IDLE;
        end else begin
          state_d    = ST_SHOW_MISS;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_COMPARE) || (state_d == ST_SHOW_MISS);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx1_q        <= 4'd0;
      idx2_q        <= 4'd0;
      val1_q        <= 4'd0;
      val2_q        <= 4'd0;
      revealed_q    <= 16'd0;
      matched_q     <= 16'd0;
      player_q      <= 1'b0;
      score0_q      <= 4'd0;
      score1_q      <= 4'd0;
      res_match_q   <= 1'b0;
      res_miss_q    <= 1'b0;
      match_pulse_q <= 1'b0;
      miss_pulse_q  <= 1'b0;
      busy_q        <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx1_q        <= idx1_d;
      idx2_q        <= idx2_d;
      val1_q        <= val1_d;
      val2_q        <= val2_d;
      revealed_q    <= revealed_d;
      matched_q     <= matched_d;
      player_q      <= player_d;
      score0_q      <= score0_d;
      score1_q      <= score1_d;
      res_match_q   <= res_match_d;
      res_miss_q    <= res_miss_d;
      match_pulse_q <= match_pulse_d;
      miss_pulse_q  <= miss_pulse_d;
      busy_q        <= busy_d;
      game_over_q   <= game_over_d;
    end
  end

  assign busy        = busy_q;
  assign revealed    = revealed_q;
  assign matched     = matched_q;
  assign player      = player_q;
  assign score0      = score0_q;
  assign score1      = score1_q;
  assign match_pulse = match_pulse_q;
  assign miss_pulse  = miss_pulse_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_match_check.sv
// ---------------------------------------------------------------------------
// tb_match_check
// Scoreboard bench for match_check: a game-level reference model predicts
// which selections are taken, the pair outcome and when its pulse is due.
// ---------------------------------------------------------------------------
module tb_match_check;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_valid;
  logic [3:0]  sel_idx;
  logic [63:0] cards;
  logic        busy;
  logic [15:0] revealed;
  logic [15:0] matched;
  logic        player;
  logic [3:0]  score0;
  logic [3:0]  score1;
  logic        match_pulse;
  logic        miss_pulse;
  logic        game_over;

  match_check #(.HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .sel_valid   (sel_valid),
    .sel_idx     (sel_idx),
    .cards       (cards),
    .busy        (busy),
    .revealed    (revealed),
    .matched     (matched),
    .player      (player),
    .score0      (score0),
    .score1      (score1),
    .match_pulse (match_pulse),
    .miss_pulse  (miss_pulse),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge n, cyc == n
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit is_match;
    int due;
  } exp_t;
  exp_t sbq[$];

  // Game-level reference model
  bit [15:0]  m_matched;
  bit         m_have_first;
  int         m_first;
  logic [3:0] m_val_first;
  int         m_player;
  int         m_score[2];
  int         m_free;    // first edge at which a selection can be taken
  int         m_settle;  // cycle from which outputs reflect the model
  bit         m_done;

  function automatic logic [3:0] val_of(input logic [63:0] b, input int k);
    return b[4*k +: 4];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_matched    = 16'h0;
    m_have_first = 1'b0;
    m_first      = 0;
    m_val_first  = 4'h0;
    m_player     = 0;
    m_score[0]   = 0;
    m_score[1]   = 0;
    m_free       = 0;
    m_settle     = 0;
    m_done       = 1'b0;
    sbq.delete();
  endtask

  // Apply the game rules to a selection sampled at edge e
  task automatic model_sel(input int e, input int idx);
    logic [3:0] v2;
    if (m_done || e < m_free || m_matched[idx] || (m_have_first && idx == m_first)) return;
    if (!m_have_first) begin
      m_have_first = 1'b1;
      m_first      = idx;
      m_val_first  = val_of(cards, idx);
      m_settle     = e;
    end else begin
      v2 = val_of(cards, idx);
      m_have_first = 1'b0;
      if (v2 == m_val_first) begin
        m_matched[m_first] = 1'b1;
        m_matched[idx]     = 1'b1;
        m_score[m_player]++;
        sbq.push_back('{1'b1, e + 2});
        m_free   = e + 2;
        m_settle = e + 1;
        if (m_matched == 16'hFFFF) m_done = 1'b1;
      end else begin
        sbq.push_back('{1'b0, e + 2});
        m_free   = e + 2 + HOLD;
        m_settle = e + 1 + HOLD;
        m_player = m_player ^ 1;
      end
    end
  endtask

  // Present one selection for one cycle; called at a falling edge
  task automatic pick(input int idx);
    sel_valid = 1'b1;
    sel_idx   = 4'(idx);
    model_sel(cyc + 1, idx);
    @(negedge clk);
    sel_valid = 1'b0;
  endtask

  task automatic wait_free();
    int g = 0;
    while (cyc + 1 < m_free && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("wait_free_bound", 32'(g < 200), 32'd1);
  endtask

  task automatic check_state(input string name);
    bit [15:0] r;
    int g = 0;
    while (cyc < m_settle && g < 200) begin
      @(negedge clk);
      g++;
    end
    r = m_matched;
    if (m_have_first) r[m_first] = 1'b1;
    chk({name, "_busy"},      32'(busy),      32'd0);
    chk({name, "_revealed"},  32'(revealed),  32'(r));
    chk({name, "_matched"},   32'(matched),   32'(m_matched));
    chk({name, "_player"},    32'(player),    32'(m_player));
    chk({name, "_score0"},    32'(score0),    32'(m_score[0]));
    chk({name, "_score1"},    32'(score1),    32'(m_score[1]));
    chk({name, "_game_over"}, 32'(game_over), 32'(m_done));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_busy"},      32'(busy),        32'd0);
    chk({name, "_revealed"},  32'(revealed),    32'd0);
    chk({name, "_matched"},   32'(matched),     32'd0);
    chk({name, "_player"},    32'(player),      32'd0);
    chk({name, "_score0"},    32'(score0),      32'd0);
    chk({name, "_score1"},    32'(score1),      32'd0);
    chk({name, "_pulses"},    32'({match_pulse, miss_pulse}), 32'd0);
    chk({name, "_game_over"}, 32'(game_over),   32'd0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    sel_valid = 1'b0;
    sel_idx   = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: every pulse must match the oldest expected outcome and its cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (sbq.size() > 0 && cyc > sbq[0].due) begin
        n_checks++;
        n_fail++;
        $display("FAIL pulse_missing: no pulse seen, expected one at cycle %0d (now %0d)",
                 sbq[0].due, cyc);
        void'(sbq.pop_front());
      end
      if (match_pulse || miss_pulse) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL pulse_unexpected: match=%0b miss=%0b at cycle %0d, none expected",
                   match_pulse, miss_pulse, cyc);
        end else begin
          exp_t ex;
          ex = sbq.pop_front();
          if (match_pulse !== ex.is_match || miss_pulse !== !ex.is_match || cyc != ex.due) begin
            n_fail++;
            $display("FAIL pulse_result: match=%0b miss=%0b at cycle %0d, expected match=%0b at cycle %0d",
                     match_pulse, miss_pulse, cyc, ex.is_match, ex.due);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] board;
    int nb;
    for (int k = 0; k < 16; k++) board[4*k +: 4] = 4'(k >> 1);
    cards     = board;
    rst       = 1'b1;
    sel_valid = 1'b0;
    sel_idx   = 4'd0;
    model_reset();

    // Reset values while rst is held
    #2;
    check_reset_outputs("reset");
    do_reset();

    // Simple match by player 0
    pick(0);
    pick(1);
    check_state("match01");
    chk("match01_matched_lit", 32'(matched), 32'h0003);

    // Miss: busy for 1+HOLD cycles with both cards shown, then hidden
    do_reset();
    pick(0);
    pick(2);
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) begin
        nb++;
        chk("miss_revealed_hold", 32'(revealed), 32'h0005);
      end
      @(negedge clk);
    end
    chk("miss_busy_len", 32'(nb), 32'(1 + HOLD));
    check_state("miss02");
    chk("miss02_player_lit", 32'(player), 32'd1);

    // Re-picking the first card and selections while busy are ignored
    do_reset();
    pick(3);
    pick(3);
    check_state("dup3");
    pick(4);
    pick(5);
    pick(6);
    check_state("busy_ignore");

    // Card change during COMPARE does not alter the latched result
    do_reset();
    pick(4);
    pick(5);
    cards[4*5 +: 4] = 4'hF;
    cards[4*4 +: 4] = 4'h9;
    @(negedge clk);
    cards = board;
    check_state("latched_cmp");

    // Reset during SHOW_MISS, then a fresh turn
    do_reset();
    pick(0);
    pick(2);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_show_miss");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    pick(6);
    pick(7);
    check_state("after_rst");

    // Full game with misses alternating the players
    do_reset();
    for (int p = 0; p < 8; p++) begin
      if (p < 7 && (p % 2) == 0) begin
        wait_free();
        pick(2 * p);
        pick(2 * p + 2);
      end
      wait_free();
      pick(2 * p);
      pick(2 * p + 1);
    end
    check_state("full_game");
    chk("full_game_over", 32'(game_over), 32'd1);
    chk("full_score_sum", 32'(score0) + 32'(score1), 32'd8);
    pick(0);
    pick(1);
    repeat (4) @(negedge clk);
    check_state("done_ignore");

    // Randomized play on the same board
    do_reset();
    for (int n = 0; n < 250; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      pick(int'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) check_state("rand");
    end
    check_state("rand_end");

    // All expected pulses must have been observed
    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
